// File: rtl/udp_tx_scheduler.sv
// Two-source round-robin front end for the shared UDP/IP transmit stack.
// Arbitrates per packet, passes the granted stream through, and enforces gap, length and stall rules.
module udp_tx_scheduler #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [15:0] SRC_PORT       = 16'd12345,
  parameter logic [15:0] CH0_DST_PORT   = 16'd12346,
  parameter logic [15:0] CH1_DST_PORT   = 16'd12347,
  parameter int unsigned MAX_LEN        = 1472,
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ch0_data,
  input  logic [15:0]           ch0_len,
  input  logic                  ch0_valid,
  input  logic                  ch0_last,
  output logic                  ch0_ready,
  input  logic [DATA_WIDTH-1:0] ch1_data,
  input  logic [15:0]           ch1_len,
  input  logic                  ch1_valid,
  input  logic                  ch1_last,
  output logic                  ch1_ready,
  output logic [DATA_WIDTH-1:0] app_data,
  output logic [15:0]           app_len,
  output logic                  app_valid,
  input  logic                  app_ready,
  output logic [15:0]           src_port,
  output logic [15:0]           dst_port,
  output logic                  grant_ch,
  output logic                  busy,
  output logic                  len_err,
  output logic                  timeout_err,
  output logic [15:0]           pkt_cnt0,
  output logic [15:0]           pkt_cnt1
);

  localparam int unsigned   TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned   GW          = $clog2(IFG_CYCLES + 1);
  localparam logic [TW-1:0] STALL_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LIMIT   = GW'(IFG_CYCLES - 1);
  localparam logic [15:0]   MAX_LEN16   = 16'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, GRANT, STREAM, GAP} state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            rr_q, rr_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     dst_q, dst_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic [TW-1:0]   stall_q, stall_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            len_err_q, len_err_d;
  logic            tmo_q, tmo_d;
  logic [15:0]     cnt0_q, cnt0_d;
  logic [15:0]     cnt1_q, cnt1_d;

  logic [DATA_WIDTH-1:0] data_g;
  logic [15:0]           len_g;
  logic                  valid_g, last_g, rdy_g, win, beat;

  assign data_g  = grant_q ? ch1_data  : ch0_data;
  assign len_g   = grant_q ? ch1_len   : ch0_len;
  assign valid_g = grant_q ? ch1_valid : ch0_valid;
  assign last_g  = grant_q ? ch1_last  : ch0_last;
  assign beat    = (state_q == STREAM) && valid_g && app_ready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    len_d     = len_q;
    dst_d     = dst_q;
    wcnt_d    = wcnt_q;
    stall_d   = stall_q;
    gap_d     = gap_q;
    len_err_d = 1'b0;
    tmo_d     = 1'b0;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    rdy_g     = 1'b0;
    win       = 1'b0;
    app_valid = 1'b0;
    app_data  = '0;
    case (state_q)
      IDLE: begin
        // rr_q names the channel that wins a tie; it flips to the loser on every grant
        if (ch0_valid || ch1_valid) begin
          win     = (ch0_valid && ch1_valid) ? rr_q : ch1_valid;
          grant_d = win;
          rr_d    = ~win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        len_d   = len_g;
        dst_d   = grant_q ? CH1_DST_PORT : CH0_DST_PORT;
        wcnt_d  = (len_g + 16'd3) >> 2;
        stall_d = '0;
        gap_d   = '0;
        if (len_g == 16'd0 || len_g > MAX_LEN16) begin
          rdy_g     = 1'b1;
          len_err_d = 1'b1;
          state_d   = GAP;
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        app_data  = data_g;
        app_valid = valid_g;
        rdy_g     = app_ready;
        if (beat) begin
          wcnt_d  = wcnt_q - 16'd1;
          stall_d = '0;
          // the packet closes on whichever of last / count-exhausted comes first
          if (last_g || wcnt_q == 16'd1) begin
            len_err_d = last_g != (wcnt_q == 16'd1);
            if (grant_q) cnt1_d = cnt1_q + 16'd1;
            else         cnt0_d = cnt0_q + 16'd1;
            state_d = GAP;
          end
        end else if (stall_q == STALL_LIMIT) begin
          tmo_d   = 1'b1;
          state_d = GAP;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LIMIT) state_d = IDLE;
        else                    gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      rr_q      <= 1'b0;
      len_q     <= '0;
      dst_q     <= '0;
      wcnt_q    <= '0;
      stall_q   <= '0;
      gap_q     <= '0;
      len_err_q <= 1'b0;
      tmo_q     <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      len_q     <= len_d;
      dst_q     <= dst_d;
      wcnt_q    <= wcnt_d;
      stall_q   <= stall_d;
      gap_q     <= gap_d;
      len_err_q <= len_err_d;
      tmo_q     <= tmo_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign ch0_ready   = rdy_g & ~grant_q;
  assign ch1_ready   = rdy_g &  grant_q;
  assign app_len     = len_q;
  assign dst_port    = dst_q;
  assign src_port    = SRC_PORT;
  assign grant_ch    = grant_q;
  assign busy        = (state_q != IDLE);
  assign len_err     = len_err_q;
  assign timeout_err = tmo_q;
  assign pkt_cnt0    = cnt0_q;
  assign pkt_cnt1    = cnt1_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed self-checking bench for udp_tx_scheduler.
// Inputs change at the falling edge; outputs are sampled 1 ns later, i.e. the values the next rising edge acts on.
module tb_udp_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ch0_data, ch1_data, app_data;
  logic [15:0] ch0_len, ch1_len, app_len, src_port, dst_port, pkt_cnt0, pkt_cnt1;
  logic        ch0_valid, ch0_last, ch0_ready, ch1_valid, ch1_last, ch1_ready;
  logic        app_valid, app_ready, grant_ch, busy, len_err, timeout_err;

  int total = 0;
  int bad   = 0;

  always #4 clk = ~clk;

  udp_tx_scheduler #(
    .DATA_WIDTH(32), .SRC_PORT(16'd12345), .CH0_DST_PORT(16'd12346), .CH1_DST_PORT(16'd12347),
    .MAX_LEN(1472), .IFG_CYCLES(12), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .rst(rst),
    .ch0_data(ch0_data), .ch0_len(ch0_len), .ch0_valid(ch0_valid), .ch0_last(ch0_last), .ch0_ready(ch0_ready),
    .ch1_data(ch1_data), .ch1_len(ch1_len), .ch1_valid(ch1_valid), .ch1_last(ch1_last), .ch1_ready(ch1_ready),
    .app_data(app_data), .app_len(app_len), .app_valid(app_valid), .app_ready(app_ready),
    .src_port(src_port), .dst_port(dst_port), .grant_ch(grant_ch), .busy(busy),
    .len_err(len_err), .timeout_err(timeout_err), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  task automatic idle_inputs();
    ch0_data = '0; ch0_len = '0; ch0_valid = 1'b0; ch0_last = 1'b0;
    ch1_data = '0; ch1_len = '0; ch1_valid = 1'b0; ch1_last = 1'b0;
    app_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [122:0] got, want;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    got  = {app_valid, app_data, app_len, dst_port, src_port, grant_ch, busy, len_err, timeout_err,
            pkt_cnt0, pkt_cnt1, ch0_ready, ch1_ready};
    want = {1'b0, 32'h0, 16'd0, 16'd0, 16'd12345, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0};
    total++;
    if (got !== want) begin bad++; $display("FAIL reset_values got=%h want=%h", got, want); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int av = 0;
    int idle_c = -1;
    do_reset();
    @(negedge clk);
    ch0_valid = 1'b1; ch0_data = 32'hDEADBEEF; ch0_len = 16'd4; ch0_last = 1'b1; app_ready = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_idle busy got=%b want=0", busy); end
    @(negedge clk); #1;
    total++;
    if ({busy, app_valid, grant_ch, ch0_ready} !== 4'b1000) begin
      bad++; $display("FAIL single_grant {busy,valid,grant,rdy} got=%b want=1000", {busy, app_valid, grant_ch, ch0_ready});
    end
    @(negedge clk); #1;
    total++;
    if ({app_valid, app_data, app_len, dst_port, src_port, ch0_ready} !==
        {1'b1, 32'hDEADBEEF, 16'd4, 16'd12346, 16'd12345, 1'b1}) begin
      bad++; $display("FAIL single_beat valid=%b data=%h len=%0d dst=%0d src=%0d rdy=%b want 1 deadbeef 4 12346 12345 1",
                      app_valid, app_data, app_len, dst_port, src_port, ch0_ready);
    end
    for (int c = 3; c <= 16; c++) begin
      @(negedge clk);
      ch0_valid = 1'b0;
      #1;
      if (app_valid) av++;
      if (!busy && idle_c < 0) idle_c = c;
      if (c == 3) begin
        total++;
        if (pkt_cnt0 !== 16'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", pkt_cnt0); end
      end
      if (c == 14) begin
        total++;
        if ({app_len, dst_port} !== {16'd4, 16'd12346}) begin
          bad++; $display("FAIL single_gap_hold len=%0d dst=%0d want 4 12346", app_len, dst_port);
        end
      end
    end
    total++;
    if (av != 0) begin bad++; $display("FAIL single_extra_valid got=%0d want=0", av); end
    total++;
    if (idle_c != 15) begin bad++; $display("FAIL single_idle_cycle got=%0d want=15", idle_c); end
  endtask

  task automatic test_round_robin();
    logic [31:0] bdata[$];
    logic        bgnt[$];
    logic [15:0] bdst[$];
    int          bcyc[$];
    int i0 = 0, i1 = 0, p0 = 0, p1 = 0;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      ch0_valid = (p0 < 2); ch0_data = {16'hC000, 8'(p0), 8'(i0)}; ch0_last = (i0 == 2); ch0_len = 16'd12;
      ch1_valid = (p1 < 2); ch1_data = {16'hC001, 8'(p1), 8'(i1)}; ch1_last = (i1 == 2); ch1_len = 16'd12;
      app_ready = 1'b1;
      #1;
      if (app_valid && app_ready) begin
        bdata.push_back(app_data); bgnt.push_back(grant_ch); bdst.push_back(dst_port); bcyc.push_back(c);
      end
      if (ch0_valid && ch0_ready) begin i0++; if (i0 == 3) begin i0 = 0; p0++; end end
      if (ch1_valid && ch1_ready) begin i1++; if (i1 == 3) begin i1 = 0; p1++; end end
    end
    idle_inputs();
    total++;
    if (bdata.size() != 12) begin bad++; $display("FAIL rr_beats got=%0d want=12", bdata.size()); end
    else begin
      for (int k = 0; k < 12; k++) begin
        int pk = k / 3;
        int ch = pk % 2;
        logic [31:0] exp_d = 32'hC000_0000 + 32'(ch << 16) + 32'((pk / 2) << 8) + 32'(k % 3);
        logic [15:0] exp_p = (ch == 1) ? 16'd12347 : 16'd12346;
        total++;
        if ({bdata[k], bgnt[k], bdst[k]} !== {exp_d, 1'(ch), exp_p}) begin
          bad++; $display("FAIL rr_beat%0d data=%h grant=%b dst=%0d want %h %0d %0d", k, bdata[k], bgnt[k], bdst[k], exp_d, ch, exp_p);
        end
      end
      for (int p = 1; p < 4; p++) begin
        total++;
        if (bcyc[3*p] - bcyc[3*p-1] != 15) begin
          bad++; $display("FAIL rr_gap%0d got=%0d want=15", p, bcyc[3*p] - bcyc[3*p-1]);
        end
      end
    end
    total++;
    if ({pkt_cnt0, pkt_cnt1} !== {16'd2, 16'd2}) begin
      bad++; $display("FAIL rr_counts got=%0d,%0d want=2,2", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_backpressure();
    int i1 = 0, nb = 0, vc = 0, viol = 0;
    do_reset();
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      ch1_valid = (i1 < 4); ch1_data = 32'h1111_0000 + 32'(i1); ch1_last = (i1 == 3); ch1_len = 16'd16;
      ch0_valid = (c >= 3); ch0_data = 32'h0BAD_0BAD; ch0_last = 1'b1; ch0_len = 16'd4;
      app_ready = (c % 2 == 0);
      #1;
      if (ch0_ready) viol++;
      if (app_valid) vc++;
      if (app_valid && app_ready) begin
        total++;
        if (app_data !== 32'h1111_0000 + 32'(nb)) begin
          bad++; $display("FAIL bp_data%0d got=%h want=%h", nb, app_data, 32'h1111_0000 + 32'(nb));
        end
        nb++;
      end
      if (ch1_valid && ch1_ready) i1++;
    end
    idle_inputs();
    total++;
    if (nb != 4) begin bad++; $display("FAIL bp_beats got=%0d want=4", nb); end
    total++;
    if (vc != 7) begin bad++; $display("FAIL bp_valid_cycles got=%0d want=7", vc); end
    total++;
    if (viol != 0) begin bad++; $display("FAIL bp_ch0_ready got=%0d want=0", viol); end
    total++;
    if ({pkt_cnt1, pkt_cnt0} !== {16'd1, 16'd0}) begin
      bad++; $display("FAIL bp_counts got=%0d,%0d want=1,0", pkt_cnt1, pkt_cnt0);
    end
  endtask

  task automatic test_len_err();
    logic [15:0] lens[3]   = '{16'd8, 16'd0, 16'd1500};
    int          exp_av[3] = '{1, 0, 0};
    int          exp_ec[3] = '{3, 2, 2};
    int          exp_rc[3] = '{2, 1, 1};
    logic [15:0] exp_n[3]  = '{16'd1, 16'd0, 16'd0};
    for (int t = 0; t < 3; t++) begin
      int av = 0, en = 0, ec = -1, rc = -1, tn = 0;
      bit sent = 1'b0;
      do_reset();
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        ch0_valid = !sent; ch0_data = 32'h5A5A_0000 + 32'(t); ch0_len = lens[t]; ch0_last = 1'b1; app_ready = 1'b1;
        #1;
        if (app_valid) av++;
        if (len_err) begin en++; ec = c; end
        if (timeout_err) tn++;
        if (ch0_valid && ch0_ready) begin rc = c; sent = 1'b1; end
      end
      idle_inputs();
      total++;
      if (av != exp_av[t]) begin bad++; $display("FAIL len%0d_valid_cycles got=%0d want=%0d", lens[t], av, exp_av[t]); end
      total++;
      if (en != 1 || ec != exp_ec[t]) begin
        bad++; $display("FAIL len%0d_err pulses=%0d at=%0d want 1 at %0d", lens[t], en, ec, exp_ec[t]);
      end
      total++;
      if (rc != exp_rc[t]) begin bad++; $display("FAIL len%0d_head_ready got=%0d want=%0d", lens[t], rc, exp_rc[t]); end
      total++;
      if ({pkt_cnt0, busy, 32'(tn)} !== {exp_n[t], 1'b0, 32'd0}) begin
        bad++; $display("FAIL len%0d_end cnt=%0d busy=%b tmo=%0d want %0d 0 0", lens[t], pkt_cnt0, busy, tn, exp_n[t]);
      end
    end
  endtask

  task automatic test_timeout();
    int idx = 0, tn = 0, tc = -1, le = 0, idle_c = -1;
    do_reset();
    for (int c = 0; c < 1050; c++) begin
      @(negedge clk);
      ch0_valid = (idx < 2); ch0_data = 32'h7000_0000 + 32'(idx); ch0_len = 16'd16; ch0_last = 1'b0; app_ready = 1'b1;
      #1;
      if (timeout_err) begin tn++; tc = c; end
      if (len_err) le++;
      if (c > 0 && !busy && idle_c < 0) idle_c = c;
      if (ch0_valid && ch0_ready) idx++;
    end
    idle_inputs();
    total++;
    if (tn != 1 || tc != 1028) begin bad++; $display("FAIL tmo_pulse count=%0d at=%0d want 1 at 1028", tn, tc); end
    total++;
    if (idle_c != 1040) begin bad++; $display("FAIL tmo_idle got=%0d want=1040", idle_c); end
    total++;
    if ({pkt_cnt0, 32'(idx), 32'(le)} !== {16'd0, 32'd2, 32'd0}) begin
      bad++; $display("FAIL tmo_end cnt=%0d beats=%0d len_err=%0d want 0 2 0", pkt_cnt0, idx, le);
    end
  endtask

  task automatic test_reset_mid();
    logic [122:0] got, want;
    int i1 = 0, nb = 0, errs = 0, dbad = 0;
    do_reset();
    @(negedge clk);
    ch0_valid = 1'b1; ch0_data = 32'hAAAA_0000; ch0_len = 16'd16; ch0_last = 1'b0; app_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    total++;
    if (app_valid !== 1'b1) begin bad++; $display("FAIL rmid_stream valid got=%b want=1", app_valid); end
    @(negedge clk);
    ch0_data = 32'hAAAA_0001; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ch0_valid = 1'b0;
    #1;
    got  = {app_valid, app_data, app_len, dst_port, src_port, grant_ch, busy, len_err, timeout_err,
            pkt_cnt0, pkt_cnt1, ch0_ready, ch1_ready};
    want = {1'b0, 32'h0, 16'd0, 16'd0, 16'd12345, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0};
    total++;
    if (got !== want) begin bad++; $display("FAIL rmid_reset_values got=%h want=%h", got, want); end
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      ch1_valid = (i1 < 2); ch1_data = 32'h2222_0000 + 32'(i1); ch1_last = (i1 == 1); ch1_len = 16'd8;
      #1;
      if (len_err || timeout_err) errs++;
      if (app_valid && app_ready) begin
        if (app_data !== 32'h2222_0000 + 32'(nb) || dst_port !== 16'd12347) dbad++;
        nb++;
      end
      if (ch1_valid && ch1_ready) i1++;
    end
    idle_inputs();
    total++;
    if ({pkt_cnt1, pkt_cnt0} !== {16'd1, 16'd0}) begin
      bad++; $display("FAIL rmid_counts got=%0d,%0d want=1,0", pkt_cnt1, pkt_cnt0);
    end
    total++;
    if (nb != 2 || dbad != 0 || errs != 0) begin
      bad++; $display("FAIL rmid_ch1 beats=%0d bad_beats=%0d errs=%0d want 2 0 0", nb, dbad, errs);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_len_err();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_tx_scheduler.md
Name: udp_tx_scheduler

Overview:
- Shares the single UDP/IP transmit stack between two packet sources: ch0 carries the IQ sample stream and ch1 carries control/telemetry.
- Arbitrates round-robin, and only at packet boundaries.
- For the granted packet it presents app_data/app_len/app_valid to the stack together with that channel's UDP port pair.
- Enforces an inter-packet gap, checks length consistency, and aborts a packet whose source stalls.

Parameters:
- DATA_WIDTH, 32, word width of channel and stack data.
- SRC_PORT, 16'd12345, UDP source port driven for every packet.
- CH0_DST_PORT, 16'd12346, destination port for ch0 packets.
- CH1_DST_PORT, 16'd12347, destination port for ch1 packets.
- MAX_LEN, 1472, largest legal payload in bytes.
- IFG_CYCLES, 12, idle cycles between packets (minimum 1).
- TIMEOUT_CYCLES, 1024, stall cycles allowed mid-packet before abort.

Ports:
- clk  in  1  125 MHz system clock.
- rst  in  1  synchronous reset, active-high.
- ch0_data  in  DATA_WIDTH  ch0 payload word.
- ch0_len  in  16  ch0 payload length in bytes; valid with the first word of a packet.
- ch0_valid  in  1  ch0 word valid.
- ch0_last  in  1  final word of the ch0 packet.
- ch0_ready  out  1  ch0 word accepted.
- ch1_data, ch1_len, ch1_valid, ch1_last, ch1_ready: same as ch0, for ch1.
- app_data  out  DATA_WIDTH  to stack.
- app_len  out  16  to stack; held for the whole packet.
- app_valid  out  1  to stack.
- app_ready  in  1  from stack.
- src_port  out  16  to stack.
- dst_port  out  16  to stack.
- grant_ch  out  1  channel currently granted.
- busy  out  1  high in any state other than IDLE.
- len_err  out  1  one-cycle pulse on a length fault.
- timeout_err  out  1  one-cycle pulse on a stall abort.
- pkt_cnt0  out  16  ch0 packets completed; wraps modulo 2^16.
- pkt_cnt1  out  16  ch1 packets completed; wraps modulo 2^16.

Behaviour:
- Reset values: app_valid 0, app_data 0, app_len 0, dst_port 0, src_port SRC_PORT, grant_ch 0, busy 0, len_err 0, timeout_err 0, pkt_cnt0/1 0, both chX_ready 0, FSM in IDLE, rr pointer favours ch0.
- Reset asserted mid-packet: immediate return to the reset state. The partial packet is dropped, not counted, and no error pulse is produced.
- State IDLE:
  - If any chX_valid is high at a clock edge, pick a winner and go to GRANT.
  - Only one valid: that channel wins.
  - Both valid: the channel that was not granted last wins; ch0 wins on the first arbitration after reset.
- State GRANT (one cycle):
  - Latch grant_ch, app_len <= chX_len, dst_port <= CHX_DST_PORT.
  - Compute expected words = ceil(len/4) (16-bit arithmetic, no overflow, since len <= MAX_LEN).
  - Load the word counter.
  - If len == 0 or len > MAX_LEN: assert chX_ready for this one cycle to consume the head word, pulse len_err, go to GAP; app_valid stays 0.
  - Otherwise go to STREAM.
- State STREAM:
  - app_data = granted chX_data and app_valid = granted chX_valid (combinational passthrough).
  - granted chX_ready = app_ready; the other channel's ready is 0.
  - A beat is transferred when valid & ready.
  - Each beat decrements the word counter and clears the stall counter.
  - The packet ends on the beat where chX_last is high or the counter reaches 1, whichever comes first.
  - Mismatch (last early, or counter exhausted without last): pulse len_err the cycle after the final beat. The packet is still counted.
  - On normal end: increment that channel's pkt_cnt, go to GAP.
  - The stall counter increments on every cycle with no beat. On reaching TIMEOUT_CYCLES: pulse timeout_err, drop app_valid, go to GAP, no count.
  - After an abort, leftover words from that source are treated as the head of a new packet.
- State GAP:
  - Hold IFG_CYCLES cycles with app_valid 0 and both readies 0, then go to IDLE.
  - dst_port and app_len keep their last values.
- Latency: valid seen at edge k → GRANT during cycle k+1 → first app_valid during cycle k+2.
- Arbitration occurs only in IDLE; a request arriving during STREAM or GAP waits.
- app_len and dst_port never change between GRANT and the end of GAP.

Test Plan:
- ch0 only, len=4, one word 0xDEADBEEF with last, app_ready=1 → app_valid one cycle at k+2 with app_data=0xDEADBEEF, app_len=4, dst_port=12346, src_port=12345; pkt_cnt0=1; busy low 12 cycles after the beat.
- ch0 and ch1 both valid continuously, each sending 3-word packets of len=12 → grants alternate 0,1,0,1; dst_port alternates 12346/12347; pkt_cnt0 = pkt_cnt1 after 4 packets; at least 12 idle cycles between packets.
- ch1 len=16, app_ready toggled 1,0,1,0 → exactly 4 beats transferred; ch0 sees no ready while ch1 holds the grant; data order preserved.
- ch0 len=8 with last on word 1 → len_err pulse one cycle, pkt_cnt0 increments. ch0 len=0 → len_err, head word consumed, no app_valid. ch0 len=1500 → same as len=0.
- ch0 len=16, valid dropped after 2 beats for 1024 cycles → timeout_err pulse, FSM back to IDLE after GAP, pkt_cnt0 unchanged.
- rst asserted during STREAM → next cycle all outputs at reset values; a following ch1 packet completes normally with pkt_cnt1=1.
